cp0_write_seq: RTL
==================

# cp0_write_seq

Sequencer that owns the single CP0 write port of the multi-cycle CPU. It accepts exception-entry, ERET and MTC0 requests from the main control FSM and arbitrates between them. It then drives the one-hot selects of the CP0 write-address mux, the CP0 write enable and the write data, one register per cycle. It sits between the control unit and the CP0 register file / write-address mux.

## Interface
- No parameters. CP0 addresses come from the shared package.
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- EXC_REQ  in  1  exception-entry request; level, held until EXC_ACK
- EXC_CODE  in  5  ExcCode for Cause[6:2]
- EXC_PC  in  32  PC of the faulting instruction, written to EPC
- ERET_REQ  in  1  ERET request; level, held until ERET_ACK
- MTC0_REQ  in  1  MTC0 request; level, held until MTC0_ACK
- MTC0_RD  in  5  destination CP0 register
- MTC0_DATA  in  32  data to write
- STATUS_Q  in  32  current Status register value (CP0 read port)
- EXC_ACK / ERET_ACK / MTC0_ACK  out  1 each  acceptance strobes, combinational
- MUXT_CP0_W_STATUS / _CAUSE / _EPC / _RD  out  1 each  one-hot write-address selects
- CP0_WE  out  1  CP0 write enable
- CP0_WDATA  out  32  CP0 write data
- BUSY  out  1  high in every state except IDLE
- DONE  out  1  high during the final write cycle of a sequence

## Operation
- States: IDLE, EXC_STATUS, EXC_CAUSE, EXC_EPC, ERET_STATUS, MTC0_WR.
- In IDLE, arbitration is fixed priority: EXC > ERET > MTC0.
  - The winner's ACK is asserted for that cycle only.
  - On the next edge its operands and STATUS_Q are captured and the FSM leaves IDLE.
  - Losers keep their REQ high and are served later.
- Exception path: EXC_STATUS → EXC_CAUSE → EXC_EPC → IDLE.
  - STATUS write: {status_cap[26:0], 5'b0}, masking interrupts.
  - CAUSE write: {25'b0, EXC_CODE_cap, 2'b0}.
  - EPC write: EXC_PC_cap.
- ERET path: ERET_STATUS → IDLE. STATUS write: {5'b0, status_cap[31:5]}.
- MTC0 path: MTC0_WR → IDLE. _RD select, data MTC0_DATA_cap. CP0 takes the address from MTC0_RD_cap, so MTC0_RD_cap is exposed to the mux.
- Write states:
  - Exactly one select high, CP0_WE=1, CP0_WDATA valid.
  - DONE=1 in EXC_EPC, ERET_STATUS and MTC0_WR.
- In IDLE all selects, CP0_WE, DONE and BUSY are 0, and CP0_WDATA is 0.
- Status is always derived from the value captured at acceptance, never from a live STATUS_Q read after the sequence's own STATUS write.
- All outputs except the ACKs are decoded from registered state and captured operands. They are glitch-free relative to the request inputs.

## Timing
- Reset values: state IDLE; all outputs 0; captured registers 0.
- Latency:
  - REQ seen in IDLE at cycle k → ACK in cycle k → first write in cycle k+1.
  - Exception: last write in k+3. ERET/MTC0: write in k+1.
- Back-to-back requests:
  - The FSM returns to IDLE after the DONE cycle, so a pending request is ACKed in the IDLE cycle.
  - Minimum spacing is one IDLE cycle between sequences.
- Simultaneous EXC and MTC0 in IDLE: EXC is ACKed; MTC0 is ACKed after the exception sequence plus one IDLE cycle.
- REQ deasserted before ACK: withdrawn, no writes.
- REQ asserted while BUSY: ignored until IDLE.
- rst_n low mid-sequence:
  - Immediate return to IDLE, outputs 0.
  - Writes already committed are not undone.
  - The interrupted request is not replayed unless still asserted after reset.

## Configuration
- CP0_WSEQ_BADVADDR_EN defined:
  - Adds input EXC_BADVADDR[31:0], output MUXT_CP0_W_BADVADDR and state EXC_BADV after EXC_EPC.
  - EXC_BADV writes EXC_BADVADDR_cap to BadVAddr.
  - DONE moves from EXC_EPC to EXC_BADV; exception latency becomes four write cycles.
- Undefined: the three-write exception sequence; no BadVAddr port or state.

## Structure
- Shared package (cp0_pkg) holds:
  - CP0 address constants: CP0_ADDR_BADVADDR=8, CP0_ADDR_STATUS=12, CP0_ADDR_CAUSE=13, CP0_ADDR_EPC=14.
  - The state encoding constants.
  - The Status shift amount (5).
- No sub-module; a single flat FSM plus a capture register bank.

## Test plan
- Exception: EXC_REQ with EXC_CODE=5'd8, EXC_PC=32'h0040_0010, STATUS_Q=32'h0000_001F → EXC_ACK in cycle k, then three writes:
  - _STATUS, data 32'h0000_03E0
  - _CAUSE, data 32'h0000_0020
  - _EPC, data 32'h0040_0010 with DONE
- ERET with STATUS_Q=32'h0000_03E0 → one _STATUS write, data 32'h0000_001F, DONE=1, BUSY=0 next cycle.
- MTC0_RD=5'd12, MTC0_DATA=32'h1234_5678 → one cycle: _RD=1, CP0_WE=1, data 32'h1234_5678, DONE=1.
- EXC_REQ and MTC0_REQ high together:
  - Exception sequence first.
  - MTC0_ACK in the IDLE cycle after DONE.
  - MTC0 write one cycle later.
- STATUS_Q changed to 32'hFFFF_FFFF after acceptance → the STATUS write still uses the captured value.
- rst_n pulsed low during EXC_CAUSE → outputs 0 at once; IDLE after release; no EPC write.

Source files
------------

// File: rtl/cp0_pkg.sv
// ============================================================================
// Module      : cp0_pkg
// Description : CP0 addresses, write-sequencer state encoding, Status shift.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cp0_pkg;

  localparam logic [4:0] CP0_ADDR_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_ADDR_STATUS   = 5'd12;
  localparam logic [4:0] CP0_ADDR_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_ADDR_EPC      = 5'd14;

  localparam int unsigned STATUS_SHIFT = 5;

  localparam logic [2:0] ST_IDLE        = 3'd0;
  localparam logic [2:0] ST_EXC_STATUS  = 3'd1;
  localparam logic [2:0] ST_EXC_CAUSE   = 3'd2;
  localparam logic [2:0] ST_EXC_EPC     = 3'd3;
  localparam logic [2:0] ST_ERET_STATUS = 3'd4;
  localparam logic [2:0] ST_MTC0_WR     = 3'd5;
  localparam logic [2:0] ST_EXC_BADV    = 3'd6;

endpackage : cp0_pkg

`default_nettype wire

// File: rtl/cp0_write_seq_if.sv
// ============================================================================
// Module      : cp0_write_seq_if
// Description : Request/ack and CP0 write-port bundle for cp0_write_seq.
//               BadVAddr signals exist only with CP0_WSEQ_BADVADDR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cp0_write_seq_if;

  logic        EXC_REQ;
  logic [4:0]  EXC_CODE;
  logic [31:0] EXC_PC;
  logic        ERET_REQ;
  logic        MTC0_REQ;
  logic [4:0]  MTC0_RD;
  logic [31:0] MTC0_DATA;
  logic [31:0] STATUS_Q;

  logic        EXC_ACK;
  logic        ERET_ACK;
  logic        MTC0_ACK;
  logic        MUXT_CP0_W_STATUS;
  logic        MUXT_CP0_W_CAUSE;
  logic        MUXT_CP0_W_EPC;
  logic        MUXT_CP0_W_RD;
  logic [4:0]  MTC0_RD_CAP;
  logic        CP0_WE;
  logic [31:0] CP0_WDATA;
  logic        BUSY;
  logic        DONE;
`ifdef CP0_WSEQ_BADVADDR_EN
  logic [31:0] EXC_BADVADDR;
  logic        MUXT_CP0_W_BADVADDR;
`endif

  // Control-unit / CP0 side
  modport master (
    output EXC_REQ, EXC_CODE, EXC_PC, ERET_REQ, MTC0_REQ, MTC0_RD, MTC0_DATA, STATUS_Q,
`ifdef CP0_WSEQ_BADVADDR_EN
    output EXC_BADVADDR,
    input  MUXT_CP0_W_BADVADDR,
`endif
    input  EXC_ACK, ERET_ACK, MTC0_ACK,
    input  MUXT_CP0_W_STATUS, MUXT_CP0_W_CAUSE, MUXT_CP0_W_EPC, MUXT_CP0_W_RD,
    input  MTC0_RD_CAP, CP0_WE, CP0_WDATA, BUSY, DONE
  );

  // Sequencer side
  modport slave (
    input  EXC_REQ, EXC_CODE, EXC_PC, ERET_REQ, MTC0_REQ, MTC0_RD, MTC0_DATA, STATUS_Q,
`ifdef CP0_WSEQ_BADVADDR_EN
    input  EXC_BADVADDR,
    output MUXT_CP0_W_BADVADDR,
`endif
    output EXC_ACK, ERET_ACK, MTC0_ACK,
    output MUXT_CP0_W_STATUS, MUXT_CP0_W_CAUSE, MUXT_CP0_W_EPC, MUXT_CP0_W_RD,
    output MTC0_RD_CAP, CP0_WE, CP0_WDATA, BUSY, DONE
  );

endinterface : cp0_write_seq_if

`default_nettype wire

// File: rtl/cp0_write_seq.sv
// ============================================================================
// Module      : cp0_write_seq
// Description : Arbitrates EXC/ERET/MTC0 requests and sequences CP0 writes,
//               one register per cycle. CP0_WSEQ_BADVADDR_EN adds a BadVAddr
//               write after EPC in the exception sequence.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cp0_write_seq
  import cp0_pkg::*;
(
  input  wire logic       clk,
  input  wire logic       rst_n,
  cp0_write_seq_if.slave  bus
);

  logic [2:0]  r_state;
  logic [2:0]  w_state_next;
  logic        w_idle;
  logic        w_exc_win;
  logic        w_eret_win;
  logic        w_mtc0_win;

  logic [31:0] r_status_cap;
  logic [4:0]  r_exc_code_cap;
  logic [31:0] r_exc_pc_cap;
  logic [4:0]  r_mtc0_rd_cap;
  logic [31:0] r_mtc0_data_cap;
`ifdef CP0_WSEQ_BADVADDR_EN
  logic [31:0] r_badvaddr_cap;
`endif

  // Fixed priority EXC > ERET > MTC0, granted only while IDLE
  assign w_idle     = (r_state == ST_IDLE);
  assign w_exc_win  = w_idle & bus.EXC_REQ;
  assign w_eret_win = w_idle & bus.ERET_REQ & ~bus.EXC_REQ;
  assign w_mtc0_win = w_idle & bus.MTC0_REQ & ~bus.EXC_REQ & ~bus.ERET_REQ;

  assign bus.EXC_ACK     = w_exc_win;
  assign bus.ERET_ACK    = w_eret_win;
  assign bus.MTC0_ACK    = w_mtc0_win;
  assign bus.MTC0_RD_CAP = r_mtc0_rd_cap;

  always_comb begin
    w_state_next = ST_IDLE;
    case (r_state)
      ST_IDLE: begin
        if (w_exc_win)       w_state_next = ST_EXC_STATUS;
        else if (w_eret_win) w_state_next = ST_ERET_STATUS;
        else if (w_mtc0_win) w_state_next = ST_MTC0_WR;
        else                 w_state_next = ST_IDLE;
      end
      ST_EXC_STATUS: w_state_next = ST_EXC_CAUSE;
      ST_EXC_CAUSE:  w_state_next = ST_EXC_EPC;
`ifdef CP0_WSEQ_BADVADDR_EN
      ST_EXC_EPC:    w_state_next = ST_EXC_BADV;
      ST_EXC_BADV:   w_state_next = ST_IDLE;
`else
      ST_EXC_EPC:    w_state_next = ST_IDLE;
`endif
      default:       w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Operands are frozen at acceptance; later STATUS_Q changes are ignored
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_status_cap    <= '0;
      r_exc_code_cap  <= '0;
      r_exc_pc_cap    <= '0;
      r_mtc0_rd_cap   <= '0;
      r_mtc0_data_cap <= '0;
`ifdef CP0_WSEQ_BADVADDR_EN
      r_badvaddr_cap  <= '0;
`endif
    end else begin
      if (w_exc_win | w_eret_win | w_mtc0_win) begin
        r_status_cap <= bus.STATUS_Q;
      end
      if (w_exc_win) begin
        r_exc_code_cap <= bus.EXC_CODE;
        r_exc_pc_cap   <= bus.EXC_PC;
`ifdef CP0_WSEQ_BADVADDR_EN
        r_badvaddr_cap <= bus.EXC_BADVADDR;
`endif
      end
      if (w_mtc0_win) begin
        r_mtc0_rd_cap   <= bus.MTC0_RD;
        r_mtc0_data_cap <= bus.MTC0_DATA;
      end
    end
  end

  always_comb begin
    bus.MUXT_CP0_W_STATUS = 1'b0;
    bus.MUXT_CP0_W_CAUSE  = 1'b0;
    bus.MUXT_CP0_W_EPC    = 1'b0;
    bus.MUXT_CP0_W_RD     = 1'b0;
`ifdef CP0_WSEQ_BADVADDR_EN
    bus.MUXT_CP0_W_BADVADDR = 1'b0;
`endif
    bus.CP0_WE    = 1'b0;
    bus.CP0_WDATA = '0;
    bus.DONE      = 1'b0;
    bus.BUSY      = ~w_idle;
    case (r_state)
      ST_EXC_STATUS: begin
        bus.MUXT_CP0_W_STATUS = 1'b1;
        bus.CP0_WE            = 1'b1;
        bus.CP0_WDATA         = r_status_cap << STATUS_SHIFT;
      end
      ST_EXC_CAUSE: begin
        bus.MUXT_CP0_W_CAUSE = 1'b1;
        bus.CP0_WE           = 1'b1;
        bus.CP0_WDATA        = {25'b0, r_exc_code_cap, 2'b0};
      end
      ST_EXC_EPC: begin
        bus.MUXT_CP0_W_EPC = 1'b1;
        bus.CP0_WE         = 1'b1;
        bus.CP0_WDATA      = r_exc_pc_cap;
`ifndef CP0_WSEQ_BADVADDR_EN
        bus.DONE           = 1'b1;
`endif
      end
`ifdef CP0_WSEQ_BADVADDR_EN
      ST_EXC_BADV: begin
        bus.MUXT_CP0_W_BADVADDR = 1'b1;
        bus.CP0_WE              = 1'b1;
        bus.CP0_WDATA           = r_badvaddr_cap;
        bus.DONE                = 1'b1;
      end
`endif
      ST_ERET_STATUS: begin
        bus.MUXT_CP0_W_STATUS = 1'b1;
        bus.CP0_WE            = 1'b1;
        bus.CP0_WDATA         = r_status_cap >> STATUS_SHIFT;
        bus.DONE              = 1'b1;
      end
      ST_MTC0_WR: begin
        bus.MUXT_CP0_W_RD = 1'b1;
        bus.CP0_WE        = 1'b1;
        bus.CP0_WDATA     = r_mtc0_data_cap;
        bus.DONE          = 1'b1;
      end
      default: begin
        bus.BUSY = 1'b0;
      end
    endcase
  end

endmodule : cp0_write_seq

`default_nettype wire
